// File: rtl/ms_timer.sv
// ms_timer: millisecond countdown timer with one-cycle done and ms_tick pulses.
// Priority on each edge is abort > start > hold > normal count.
module ms_timer #(
    parameter int CLK_FREQ_HZ = 5000000,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_dur_ms,
    input  logic             i_abort,
    input  logic             i_hold,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_ms_tick,
    output logic [CNT_W-1:0] o_remain_ms
);
    localparam int TICKS_PER_MS = CLK_FREQ_HZ / 1000;
    localparam int PW           = $clog2(TICKS_PER_MS);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [PW-1:0]    r_presc;
    logic [CNT_W-1:0] r_remain;
    logic             r_done;
    logic             r_tick;
    logic             w_ms_end;

    assign w_ms_end    = r_presc == PW'(TICKS_PER_MS - 1);
    assign o_busy      = r_state == S_RUN;
    assign o_done      = r_done;
    assign o_ms_tick   = r_tick;
    assign o_remain_ms = r_remain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            r_remain <= '0;
            r_done   <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_tick <= 1'b0;
            if (i_abort) begin
                r_state  <= S_IDLE;
                r_presc  <= '0;
                r_remain <= '0;
            end else if (i_start) begin
                // a zero duration expires immediately, from IDLE or as a restart
                r_presc  <= '0;
                r_remain <= i_dur_ms;
                r_state  <= (i_dur_ms != '0) ? S_RUN : S_IDLE;
                r_done   <= i_dur_ms == '0;
            end else if (r_state == S_RUN && !i_hold) begin
                r_presc <= w_ms_end ? '0 : r_presc + 1'b1;
                if (w_ms_end) begin
                    r_remain <= r_remain - 1'b1;
                    r_tick   <= 1'b1;
                    if (r_remain == CNT_W'(1)) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ms_timer.sv
// tb_ms_timer: randomized scoreboard bench for ms_timer against a cycles-left reference model.
// A second default-parameter instance checks the real 5 MHz latency.
module tb_ms_timer;
    localparam int T = 10;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        tick;
        logic [15:0] rem;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, hold = 1'b0;
    logic [15:0] dur = '0;
    logic        busy, done, tick;
    logic [15:0] remain;
    logic        start2 = 1'b0;
    logic [15:0] dur2 = '0;
    logic        busy2, done2, tick2;
    logic [15:0] remain2;

    exp_t q[$];
    exp_t mon_e;
    int   vectors = 0, errors = 0;
    int   m_left = 0;
    bit   m_busy = 1'b0;
    int   n, busy_cnt;
    bit   seen;

    always #100 clk = ~clk;

    ms_timer #(.CLK_FREQ_HZ(10000)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_dur_ms(dur),
        .i_abort(abort), .i_hold(hold), .o_busy(busy), .o_done(done),
        .o_ms_tick(tick), .o_remain_ms(remain)
    );

    ms_timer dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_dur_ms(dur2),
        .i_abort(1'b0), .i_hold(1'b0), .o_busy(busy2), .o_done(done2),
        .o_ms_tick(tick2), .o_remain_ms(remain2)
    );

    task automatic check(string name, exp_t act, exp_t exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got busy=%0b done=%0b tick=%0b rem=%0d, expected busy=%0b done=%0b tick=%0b rem=%0d",
                     name, $time, act.busy, act.done, act.tick, act.rem, exp.busy, exp.done, exp.tick, exp.rem);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("cycle", {busy, done, tick, remain}, mon_e);
        end
    end

    // Model: a run is just a number of un-held cycles left; whole ms remaining is its ceiling.
    task automatic step(bit s, logic [15:0] d, bit a, bit h);
        exp_t e;
        bit   m_done = 1'b0, m_tick = 1'b0;
        start = s; dur = d; abort = a; hold = h;
        if (a) begin
            m_busy = 1'b0; m_left = 0;
        end else if (s) begin
            if (d != 0) begin m_busy = 1'b1; m_left = int'(d) * T; end
            else begin m_busy = 1'b0; m_left = 0; m_done = 1'b1; end
        end else if (m_busy && !h) begin
            m_left--;
            m_tick = (m_left % T) == 0;
            if (m_left == 0) begin m_busy = 1'b0; m_done = 1'b1; end
        end
        e.busy = m_busy; e.done = m_done; e.tick = m_tick;
        e.rem  = 16'((m_left + T - 1) / T);
        @(posedge clk); #1;
        q.push_back(e);
        start = 1'b0; abort = 1'b0; hold = 1'b0;
    endtask

    task automatic idle(int k);
        repeat (k) step(1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #50;
        check("reset_state", {busy, done, tick, remain}, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 16'd3, 1'b0, 1'b0); idle(35);
        step(1'b1, 16'd0, 1'b0, 1'b0); idle(5);
        step(1'b1, 16'd5, 1'b0, 1'b0); idle(20);
        repeat (7) step(1'b0, 16'd0, 1'b0, 1'b1);
        idle(40);
        step(1'b1, 16'd4, 1'b0, 1'b0); idle(14); step(1'b0, 16'd0, 1'b1, 1'b0); idle(10);
        step(1'b1, 16'd4, 1'b0, 1'b0); idle(14); step(1'b1, 16'd2, 1'b0, 1'b0); idle(25);
        step(1'b1, 16'd1, 1'b0, 1'b0); idle(9); step(1'b0, 16'd0, 1'b1, 1'b0); idle(12);
        step(1'b1, 16'd1, 1'b0, 1'b0); idle(9); step(1'b1, 16'd1, 1'b0, 1'b0); idle(12);
        step(1'b1, 16'd1, 1'b0, 1'b0); idle(9); step(1'b0, 16'd0, 1'b0, 1'b1); idle(3);
        step(1'b1, 16'd2, 1'b0, 1'b0); step(1'b0, 16'd0, 1'b0, 1'b1); idle(3);
        repeat (4000) begin
            step($urandom_range(0, 39) == 0, 16'($urandom_range(0, 4)),
                 $urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0);
        end
        idle(60);
        step(1'b1, 16'd5, 1'b0, 1'b0); idle(21);
        @(negedge clk); #20;
        rst_n = 1'b0; #1;
        check("reset_async", {busy, done, tick, remain}, '0);
        m_busy = 1'b0; m_left = 0;
        @(posedge clk); #1;
        check("reset_held", {busy, done, tick, remain}, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle(100);
        @(negedge clk); #1;
        check_int("queue_drained", q.size(), 0);
        @(posedge clk); #1;
        start2 = 1'b1; dur2 = 16'd2;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && n <= 12000) begin
            @(negedge clk);
            if (done2) seen = 1'b1;
            else begin
                if (busy2) busy_cnt++;
                n++;
            end
        end
        check_int("default_done_seen", int'(seen), 1);
        check_int("default_done_latency", n, 10000);
        check_int("default_busy_cycles", busy_cnt, 10000);
        check_int("default_busy_at_done", int'(busy2), 0);
        check_int("default_remain_at_done", int'(remain2), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ms_timer.md
Name: ms_timer

Overview:
- Millisecond countdown timer; the counterpart of the ms up-counter.
- Software or an FSM loads a duration in ms. The block counts it down from the system clock and signals expiry with a one-cycle done pulse.
- Sits beside ms_cnt on the same 5 MHz clock domain and serves as the delay/timeout generator for control FSMs.

Parameters:
- CLK_FREQ_HZ, 5000000, input clock frequency. Must be a multiple of 1000 and >= 2000.
- CNT_W, 16, width of the duration and remaining-time counters.
- TICKS_PER_MS, derived as CLK_FREQ_HZ/1000 (5000 by default). Not overridable.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset. All state clears immediately while rst=0.
- start  input  1  load-and-run strobe, sampled each rising edge.
- dur_ms  input  CNT_W  duration in ms, captured on the edge where start=1 is accepted.
- abort  input  1  cancel the running countdown.
- hold  input  1  pause. Prescaler and remain_ms freeze while high.
- busy  output  1  countdown in progress.
- done  output  1  one-cycle expiry pulse.
- ms_tick  output  1  one-cycle pulse on every ms decrement, including the final one.
- remain_ms  output  CNT_W  remaining whole milliseconds.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, prescaler=0, remain_ms=0, busy=0, done=0, ms_tick=0.
- State encoding: IDLE, RUN. done and ms_tick are registered pulses, not separate states.
- Prescaler is an internal counter of ceil(log2(TICKS_PER_MS)) bits that counts 0..TICKS_PER_MS-1 in RUN.
- IDLE with start=1, dur_ms>0 (edge E0): remain_ms<=dur_ms, prescaler<=0, state<=RUN, busy=1 after E0.
- IDLE with start=1, dur_ms=0: stay IDLE, done=1 for the single cycle after E0. busy and ms_tick stay 0.
- RUN, hold=0: prescaler increments each edge.
  - When prescaler==TICKS_PER_MS-1, prescaler<=0 and remain_ms decrements.
  - ms_tick=1 for the cycle after that edge.
- Expiry: the decrement that takes remain_ms 1->0 also sets state<=IDLE, busy<=0, done<=1 (one cycle), ms_tick<=1.
- Latency: done is high in the cycle after edge E0 + dur_ms*TICKS_PER_MS, i.e. exactly dur_ms ms after acceptance. busy is high for exactly dur_ms*TICKS_PER_MS cycles.
- RUN, hold=1: prescaler and remain_ms frozen, busy stays 1, no ms_tick. Countdown resumes where it left off. hold is ignored in IDLE.
- start while RUN: restart. Reload dur_ms, prescaler<=0, no done for the abandoned run. dur_ms=0 here behaves as the IDLE zero case: go IDLE, pulse done.
- abort (any state): state<=IDLE, busy<=0, prescaler<=0, remain_ms<=0, no done, no ms_tick.
- Simultaneous events, priority: abort > start > hold > normal count.
  - abort on the same edge as the final decrement suppresses done.
  - start on the final-decrement edge restarts; done is suppressed.
  - hold on the final-decrement edge freezes the count (remain_ms stays 1).
- remain_ms holds 0 in IDLE after expiry or abort. It never wraps below 0.
- Reset asserted mid-run: immediate return to reset values. No done after release until a new start.
- Outputs are driven only from registers; no combinational path from inputs to outputs.

Test Plan:
- CLK_FREQ_HZ=10000 (TICKS_PER_MS=10), period 200 ns. start pulse with dur_ms=3 at E0 -> busy high 30 cycles; ms_tick after E0+10, +20, +30; remain_ms 3->2->1->0; done one cycle after E0+30.
- Default parameters, dur_ms=2 -> done exactly 10000 cycles (2,000,000 ns) after acceptance; busy falls on the same edge.
- dur_ms=0 start -> done for one cycle after the start edge; busy never asserts; ms_tick stays 0.
- dur_ms=5 with hold high for 7 cycles mid-run -> done delayed by exactly 7 cycles (57 cycles total at TICKS_PER_MS=10); no ms_tick during hold.
- dur_ms=4, then abort at cycle 15 -> busy=0 and remain_ms=0 next cycle; no done. A separate run restarted at cycle 15 with dur_ms=2 -> done after 20 further cycles only.
- Drive rst low asynchronously (mid clock period) during a run with remain_ms=3 -> all outputs 0 immediately; after release with no start, done stays 0 for 100 cycles.
